// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton front end: per channel a 2-flop synchroniser, counter
// debouncer, registered level, press/auto-repeat pulse and release pulse.
module btn_conditioner #(
   parameter int unsigned N          = 4,
   parameter int unsigned DB_CYCLES  = 4,
   parameter int unsigned RPT_DELAY  = 16,
   parameter int unsigned RPT_PERIOD = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] key_i,
   input  logic [N-1:0] rpt_en_i,
   output logic [N-1:0] level_o,
   output logic [N-1:0] out_o,
   output logic [N-1:0] release_o
);

   localparam int unsigned CNT_W   = $clog2(DB_CYCLES + 1);
   localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int unsigned RC_W    = $clog2(RPT_MAX + 1);

   typedef enum logic [1:0] {
      ST_RELEASED = 2'd0,
      ST_HOLD_DLY = 2'd1,
      ST_HOLD_RPT = 2'd2
   } state_e;

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic             s1_q, s2_q;
      logic             level_q, level_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [RC_W-1:0]  rc_q, rc_d;
      state_e           state_q, state_d;
      logic             out_q, out_d;
      logic             rel_q, rel_d;
      logic             rpt_due;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rc_q    <= '0;
            state_q <= ST_RELEASED;
            out_q   <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            s1_q    <= key_i[i];
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
            state_q <= state_d;
            out_q   <= out_d;
            rel_q   <= rel_d;
         end
      end

      // Level flips on the edge the disagreement run would reach DB_CYCLES samples.
      always_comb begin
         level_d = level_q;
         cnt_d   = '0;
         if (s2_q != level_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
               level_d = ~level_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      always_comb begin
         rpt_due = ((state_q == ST_HOLD_DLY) && (rc_q == RC_W'(RPT_DELAY - 1))) ||
                   ((state_q == ST_HOLD_RPT) && (rc_q == RC_W'(RPT_PERIOD - 1)));
      end

      // Pulses are computed from level_d so they line up with the registered level edge.
      always_comb begin
         state_d = state_q;
         rc_d    = rc_q;
         out_d   = 1'b0;
         rel_d   = 1'b0;
         case (state_q)
            ST_RELEASED: begin
               if (level_d) begin
                  state_d = ST_HOLD_DLY;
                  rc_d    = '0;
                  out_d   = 1'b1;
               end
            end
            ST_HOLD_DLY, ST_HOLD_RPT: begin
               if (!level_d) begin
                  state_d = ST_RELEASED;
                  rc_d    = '0;
                  rel_d   = 1'b1;
               end else if (!rpt_en_i[i]) begin
                  state_d = ST_HOLD_DLY;
                  rc_d    = '0;
               end else if (rpt_due) begin
                  state_d = ST_HOLD_RPT;
                  rc_d    = '0;
                  out_d   = 1'b1;
               end else begin
                  rc_d = rc_q + RC_W'(1);
               end
            end
            default: begin
               state_d = ST_RELEASED;
               rc_d    = '0;
            end
         endcase
      end

      assign level_o[i]   = level_q;
      assign out_o[i]     = out_q;
      assign release_o[i] = rel_q;
   end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Multi-channel pushbutton front end for the lab top level. It is the parametrised successor of the single-key press-to-pulse FSM.
- Each channel gets:
  - a 2-flop synchroniser
  - a counter-based debouncer
  - a clean level output
  - a one-cycle press pulse, with optional per-channel auto-repeat while held
  - a one-cycle release pulse
- Sits between raw KEY/SW pins and game/control FSMs.

Parameters:
- N, 4: number of independent key channels (>=1).
- DB_CYCLES, 4: consecutive stable synchronised samples required before the debounced level changes (>=1).
- RPT_DELAY, 16: cycles from the press pulse to the first repeat pulse (>=1).
- RPT_PERIOD, 4: cycles between successive repeat pulses (>=1).

Ports:
- clk  in  1  system clock, all flops on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- key  in  N  raw asynchronous key inputs, 1 = pressed (polarity inversion done outside).
- rpt_en  in  N  per-channel auto-repeat enable, synchronous to clk.
- level  out  N  debounced key state.
- out  out  N  one-cycle pulse on press and on each auto-repeat.
- release  out  N  one-cycle pulse when the debounced level falls.

Behaviour:
- Reset:
  - reset low immediately clears every flop, independent of clk: sync chain, debounce counters, repeat counters, FSM state (RELEASED), level, out, release.
  - All outputs read 0 while reset is low.
- Channel independence: channels share nothing but clk and reset. Each channel's logic is identical and independent.
- Synchroniser:
  - key[i] -> s1 -> s2 (key_s); 2 edges of latency.
  - No logic reads s1.
- Debounce:
  - cnt[i] increments on each edge where key_s != level; it is cleared on any edge where key_s == level.
  - On the edge where cnt would reach DB_CYCLES, level toggles and cnt clears.
  - Width is $clog2(DB_CYCLES+1); the counter never wraps.
- Latency: counting the first edge that samples key=1 as edge 1, level rises at edge DB_CYCLES+2 (edge 6 at defaults). Release is symmetric.
- Glitch rejection: any key_s run shorter than DB_CYCLES never changes level and produces no pulse.
- Per-channel FSM:
  - RELEASED: level=0. On level 0->1, go to HOLD_DLY; out=1 for the cycle level first reads 1; repeat counter rc=0.
  - HOLD_DLY:
    - level=1, rc counts each cycle while rpt_en=1.
    - At rc==RPT_DELAY-1: out=1 next cycle, rc=0, go to HOLD_RPT.
  - HOLD_RPT: rc counts; at rc==RPT_PERIOD-1, out=1 next cycle and rc=0.
  - Any hold state:
    - level 1->0: go to RELEASED and pulse release=1 for the cycle level first reads 0. No out pulse is issued in that cycle.
    - rpt_en=0: rc held at 0, no repeat pulses, state forced to HOLD_DLY.
    - If rpt_en re-asserts while still held, the full RPT_DELAY is waited again.
- Repeat timing: press pulse in cycle P gives repeats in cycles P+RPT_DELAY, then P+RPT_DELAY+k*RPT_PERIOD.
- Pulse width: out and release are registered and never high for 2 consecutive cycles.
  - Exception: out may be high on consecutive cycles only if RPT_PERIOD=1 (legal; continuous repeat).
- Key held through reset: after reset deasserts, level starts at 0. The held key is a new press: level rises DB_CYCLES+2 edges after reset release, with a press pulse.
- Simultaneous events: press on one channel and release on another in the same cycle are both reported in that cycle.

Test Plan:
- Reset dominance: hold reset=0, toggle key=4'hF every cycle for 10 cycles -> level/out/release all 0. Assert reset=0 between clk edges -> outputs clear before the next edge.
- Clean press/release ch0:
  - Stimulus: rpt_en=0; key[0]=1 for 20 cycles, then 0.
  - Press: level[0]=1 at edge 6; out[0] high exactly 1 cycle, at that edge; no further out.
  - Release: level[0]=0 at 6th edge after the fall; release[0] high exactly 1 cycle.
- Bounce:
  - Stimulus: key[0] = 1,1,1,0,1,1,1,1,... then held high.
  - No level change from the first 3-cycle burst.
  - level[0] rises 4 edges after key_s is stable high; exactly one out pulse.
- Auto-repeat ch1: rpt_en[1]=1, key[1] held 40 cycles with press pulse at cycle P -> out[1] pulses at P, P+16, P+20, P+24, ... until release; no out in the release cycle.
- Mixed channels:
  - Stimulus: key[2] and key[3] pressed on the same edge, rpt_en[2]=1, rpt_en[3]=0; drop rpt_en[2] at P+18.
  - out[2] and out[3] pulse together at P.
  - out[2] pulses at P+16 only; it resumes at P+16 after rpt_en[2] re-asserts.
- Reset mid-hold:
  - Stimulus: with key[1] held in HOLD_RPT, pulse reset low for 3 cycles, key stays high.
  - Outputs are 0 during reset.
  - Fresh press: level[1] and out[1] rise at the 6th edge after reset release.
